// File: rtl/test_ddr.sv
// ---------------------------------------------------------------------------
// test_ddr : DDR3 self-test traffic engine for board bring-up.
//
// After the memory controller reports ddr_init_done, the engine loops forever:
// it writes a seeded pattern to a linear region, reads that region back and
// compares every returned word. Each completed pass bumps pass_cnt and the
// seed. Mismatches (and unsolicited read beats) bump a saturating err_cnt and
// set a sticky err_flag_led. A free-running heartbeat toggles heart_beat_led.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   ddr_init_done     controller calibration complete
//   cmd_valid/ready   command handshake to the controller user port
//   cmd_write         1 = write, 0 = read
//   cmd_addr          word address (index * ADDR_STEP)
//   cmd_wdata         write data, carried with the write command
//   rd_valid/rd_data  read beats, returned in command order
//   heart_beat_led    heartbeat indicator
//   err_flag_led      sticky mismatch indicator
//   pass_cnt          completed passes (wraps)
//   err_cnt           bad read beats (saturates at 0xFFFF)
//   uart_txd          8N1 pass/fail byte per pass ('P'/'F'), only when the
//                     macro TEST_DDR_UART_EN is defined
// ---------------------------------------------------------------------------
module test_ddr #(
    parameter int ADDR_WIDTH    = 28,
    parameter int DATA_WIDTH    = 256,
    parameter int TEST_WORDS    = 1024,
    parameter int ADDR_STEP     = 8,
    parameter int HEARTBEAT_DIV = 50_000_000
`ifdef TEST_DDR_UART_EN
    ,
    parameter int BAUD_DIV      = 434
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ddr_init_done,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic                  cmd_write,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  heart_beat_led,
    output logic                  err_flag_led,
    output logic [15:0]           pass_cnt,
    output logic [15:0]           err_cnt
`ifdef TEST_DDR_UART_EN
    ,
    output logic                  uart_txd
`endif
);

    // Index registers must be able to hold TEST_WORDS itself (ri "done" value).
    localparam int IDX_W = $clog2(TEST_WORDS) + 1;
    localparam int HB_W  = (HEARTBEAT_DIV > 1) ? $clog2(HEARTBEAT_DIV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TEST_WORDS - 1);
    localparam logic [IDX_W-1:0] ALL_IDX  = IDX_W'(TEST_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DONE} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] wi_q, ri_q, rc_q;
    logic [31:0]      seed_q;
    logic [15:0]      pass_cnt_q, err_cnt_q;
    logic             err_flag_q;
    logic [HB_W-1:0]  hb_cnt_q;
    logic             hb_led_q;

    // Word i of a pass is DATA_WIDTH/32 copies of (i ^ seed).
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [IDX_W-1:0] idx,
                                                      input logic [31:0]      seed);
        logic [DATA_WIDTH-1:0] p;
        logic [31:0]           w;
        w = 32'(idx) ^ seed;
        for (int k = 0; k < DATA_WIDTH / 32; k++) p[k*32 +: 32] = w;
        return p;
    endfunction

    // Command outputs decode straight from registered state so they cannot
    // change while a command is stalled on cmd_ready.
    logic             issuing;
    logic [IDX_W-1:0] cur_idx;
    logic             cmd_hs;
    logic             beat_expected;
    logic             beat_bad;

    assign issuing   = (state_q == ST_WRITE) || ((state_q == ST_READ) && (ri_q != ALL_IDX));
    assign cur_idx   = (state_q == ST_WRITE) ? wi_q : ri_q;
    assign cmd_hs    = issuing && cmd_ready;

    assign cmd_valid = issuing;
    assign cmd_write = (state_q == ST_WRITE);
    assign cmd_addr  = issuing ? ADDR_WIDTH'(64'(cur_idx) * 64'(ADDR_STEP)) : '0;
    assign cmd_wdata = (state_q == ST_WRITE) ? pattern(wi_q, seed_q) : '0;

    // A beat is only legitimate while a read pass still expects data; any
    // other beat is an error and its data is ignored.
    assign beat_expected = (state_q == ST_READ) && (rc_q != ALL_IDX);
    assign beat_bad      = rd_valid && (!beat_expected || (rd_data != pattern(rc_q, seed_q)));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register reads the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wi_q       <= '0;
            ri_q       <= '0;
            rc_q       <= '0;
            seed_q     <= '0;
            pass_cnt_q <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else begin
            if (beat_bad) begin
                err_flag_q <= 1'b1;
                if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (ddr_init_done) begin
                        state_q <= ST_WRITE;
                        wi_q    <= '0;
                    end
                end
                ST_WRITE: begin
                    if (!ddr_init_done) begin
                        state_q <= ST_IDLE;
                        wi_q    <= '0;
                        ri_q    <= '0;
                        rc_q    <= '0;
                    end else if (cmd_hs) begin
                        if (wi_q == LAST_IDX) begin
                            state_q <= ST_READ;
                            ri_q    <= '0;
                            rc_q    <= '0;
                        end else begin
                            wi_q <= wi_q + 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (!ddr_init_done) begin
                        state_q <= ST_IDLE;
                        wi_q    <= '0;
                        ri_q    <= '0;
                        rc_q    <= '0;
                    end else begin
                        // Issue and receive sides advance independently.
                        if (cmd_hs) ri_q <= ri_q + 1'b1;
                        if (rd_valid && beat_expected) begin
                            rc_q <= rc_q + 1'b1;
                            if (rc_q == LAST_IDX) state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    pass_cnt_q <= pass_cnt_q + 16'd1;
                    seed_q     <= seed_q + 32'd1;
                    wi_q       <= '0;
                    state_q    <= ddr_init_done ? ST_WRITE : ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Heartbeat runs independently of the test state.
    always_ff @(posedge clk) begin
        if (rst) begin
            hb_cnt_q <= '0;
            hb_led_q <= 1'b0;
        end else if (hb_cnt_q == HB_W'(HEARTBEAT_DIV - 1)) begin
            hb_cnt_q <= '0;
            hb_led_q <= ~hb_led_q;
        end else begin
            hb_cnt_q <= hb_cnt_q + 1'b1;
        end
    end

    assign heart_beat_led = hb_led_q;
    assign err_flag_led   = err_flag_q;
    assign pass_cnt       = pass_cnt_q;
    assign err_cnt        = err_cnt_q;

`ifdef TEST_DDR_UART_EN
    localparam int BD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic            tx_active_q;
    logic [8:0]      tx_shift_q;   // remaining data bits plus stop bit
    logic [3:0]      tx_bits_q;    // bits still to shift after the current one
    logic [BD_W-1:0] tx_baud_q;
    logic            uart_txd_q;

    // One byte per DONE; a DONE that arrives mid-frame is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_active_q <= 1'b0;
            tx_shift_q  <= '0;
            tx_bits_q   <= '0;
            tx_baud_q   <= '0;
            uart_txd_q  <= 1'b1;
        end else if (!tx_active_q) begin
            if (state_q == ST_DONE) begin
                tx_active_q <= 1'b1;
                uart_txd_q  <= 1'b0;
                tx_shift_q  <= {1'b1, (err_cnt_q == 16'd0) ? 8'h50 : 8'h46};
                tx_bits_q   <= 4'd9;
                tx_baud_q   <= '0;
            end
        end else if (tx_baud_q == BD_W'(BAUD_DIV - 1)) begin
            tx_baud_q <= '0;
            if (tx_bits_q == 4'd0) begin
                tx_active_q <= 1'b0;
            end else begin
                uart_txd_q <= tx_shift_q[0];
                tx_shift_q <= {1'b0, tx_shift_q[8:1]};
                tx_bits_q  <= tx_bits_q - 4'd1;
            end
        end else begin
            tx_baud_q <= tx_baud_q + 1'b1;
        end
    end

    assign uart_txd = uart_txd_q;
`endif

endmodule

// File: tb/tb_test_ddr.sv
// ---------------------------------------------------------------------------
// tb_test_ddr : self-checking bench for test_ddr.
// A single process steps the clock on falling edges, acts as the memory
// controller (echo memory with in-order read return), and keeps a scoreboard
// of expected commands pushed per pass and popped on every handshake.
// ---------------------------------------------------------------------------
module tb_test_ddr;

    localparam int AW   = 28;
    localparam int DW   = 256;
    localparam int TW   = 4;
    localparam int STEP = 8;
    localparam int HB   = 4;
    localparam int BAUD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          ddr_init_done;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          heart_beat_led;
    logic          err_flag_led;
    logic [15:0]   pass_cnt;
    logic [15:0]   err_cnt;
`ifdef TEST_DDR_UART_EN
    logic          uart_txd;
`endif

    test_ddr #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .TEST_WORDS   (TW),
        .ADDR_STEP    (STEP),
        .HEARTBEAT_DIV(HB)
`ifdef TEST_DDR_UART_EN
        ,
        .BAUD_DIV     (BAUD)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ddr_init_done (ddr_init_done),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .heart_beat_led(heart_beat_led),
        .err_flag_led  (err_flag_led),
        .pass_cnt      (pass_cnt),
        .err_cnt       (err_cnt)
`ifdef TEST_DDR_UART_EN
        ,
        .uart_txd      (uart_txd)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    cmd_t          expq[$];
    logic [DW-1:0] rdq[$];
    logic [DW-1:0] mem[int];

    int vectors     = 0;
    int miscompares = 0;

    int            ready_mode = 0;   // 0: always ready, 1: random, 2: never
    bit            corrupt_armed = 1'b0;
    bit            inject_rd = 1'b0;
    bit            prev_stall = 1'b0;
    logic          prev_write;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;

    bit            rx_busy = 1'b0;
    int            rx_t = 0;
    logic [9:0]    rx_bits;
    logic [9:0]    rx_frames[$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int i, input int s);
        logic [DW-1:0] p;
        logic [31:0]   w;
        w = 32'(i) ^ 32'(s);
        for (int k = 0; k < DW / 32; k++) p[k*32 +: 32] = w;
        return p;
    endfunction

    task automatic push_pass(input int s);
        cmd_t c;
        for (int i = 0; i < TW; i++) begin
            c.wr = 1'b1; c.addr = AW'(i * STEP); c.data = pat(i, s);
            expq.push_back(c);
        end
        for (int i = 0; i < TW; i++) begin
            c.wr = 1'b0; c.addr = AW'(i * STEP); c.data = '0;
            expq.push_back(c);
        end
    endtask

    // One clock cycle: drive controller inputs on the falling edge and
    // account for the handshake the next rising edge will perform.
    task automatic step();
        cmd_t          c;
        logic [DW-1:0] d;
        @(negedge clk);
        if (prev_stall && ddr_init_done && !rst) begin
            check("stall_valid", cmd_valid, 1'b1);
            check("stall_write", cmd_write, prev_write);
            check("stall_addr", cmd_addr, prev_addr);
            check("stall_wdata", cmd_wdata, prev_wdata);
        end
        case (ready_mode)
            0:       cmd_ready = 1'b1;
            1:       cmd_ready = 1'($urandom_range(0, 1));
            default: cmd_ready = 1'b0;
        endcase
        rd_valid = 1'b0;
        rd_data  = '0;
        if (inject_rd) begin
            rd_valid  = 1'b1;
            rd_data   = {8{$urandom()}};
            inject_rd = 1'b0;
        end else if (rdq.size() > 0 && (ready_mode != 1 || $urandom_range(0, 1) == 1)) begin
            rd_valid = 1'b1;
            rd_data  = rdq.pop_front();
        end
        if (cmd_valid && cmd_ready) begin
            if (expq.size() == 0) begin
                check("unexpected_cmd", cmd_valid, 1'b0);
            end else begin
                c = expq.pop_front();
                check("cmd_write", cmd_write, c.wr);
                check("cmd_addr", cmd_addr, c.addr);
                if (c.wr) begin
                    check("cmd_wdata", cmd_wdata, c.data);
                    mem[int'(cmd_addr)] = cmd_wdata;
                end else begin
                    d = mem.exists(int'(cmd_addr)) ? mem[int'(cmd_addr)] : '0;
                    if (corrupt_armed && int'(cmd_addr) == 2 * STEP) begin
                        d[5] = ~d[5];
                        corrupt_armed = 1'b0;
                    end
                    rdq.push_back(d);
                end
            end
        end
        prev_stall = cmd_valid && !cmd_ready;
        prev_write = cmd_write;
        prev_addr  = cmd_addr;
        prev_wdata = cmd_wdata;
`ifdef TEST_DDR_UART_EN
        if (!rx_busy) begin
            if (uart_txd === 1'b0) begin
                rx_busy = 1'b1;
                rx_t    = 0;
            end
        end else begin
            rx_t++;
        end
        if (rx_busy && (rx_t % BAUD) == BAUD / 2) begin
            rx_bits[rx_t / BAUD] = uart_txd;
            if (rx_t / BAUD == 9) begin
                rx_frames.push_back(rx_bits);
                rx_busy = 1'b0;
            end
        end
`endif
    endtask

    task automatic wait_pass(input int target);
        int n = 0;
        while (pass_cnt != 16'(target) && n < 3000) begin
            step();
            n++;
        end
        check("pass_cnt", pass_cnt, target);
    endtask

    // Drop ddr_init_done while writes are in progress; the engine must go
    // idle on the next edge with the pass count untouched.
    task automatic abort_now(input int exp_pass);
        ready_mode    = 2;
        ddr_init_done = 1'b0;
        step();
        step();
        check("abort_valid", cmd_valid, 1'b0);
        check("abort_addr", cmd_addr, '0);
        check("abort_pass", pass_cnt, exp_pass);
        expq.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, cmd_valid, 1'b0);
        check({tag, "_write"}, cmd_write, 1'b0);
        check({tag, "_addr"}, cmd_addr, '0);
        check({tag, "_wdata"}, cmd_wdata, '0);
        check({tag, "_pass"}, pass_cnt, '0);
        check({tag, "_errcnt"}, err_cnt, '0);
        check({tag, "_errflag"}, err_flag_led, 1'b0);
`ifdef TEST_DDR_UART_EN
        check({tag, "_txd"}, uart_txd, 1'b1);
`endif
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        ddr_init_done = 1'b0;
        cmd_ready     = 1'b0;
        rd_valid      = 1'b0;
        rd_data       = '0;

        // Reset values and heartbeat cadence from reset release.
        repeat (3) step();
        check_reset_state("reset");
        check("reset_hb", heart_beat_led, 1'b0);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("heartbeat", heart_beat_led, (k / 4) % 2);
        end
        check("idle_valid", cmd_valid, 1'b0);

        // Clean passes with an always-ready controller.
        push_pass(0);
        push_pass(1);
        ddr_init_done = 1'b1;
        wait_pass(1);
        check("p1_errcnt", err_cnt, '0);
        check("p1_errflag", err_flag_led, 1'b0);
        push_pass(2);
        wait_pass(2);
        push_pass(3);

        // Abort after two writes of the third pass, then restart at addr 0.
        n = 0;
        while (expq.size() > 4 * TW - 2 && n < 100) begin
            step();
            n++;
        end
        abort_now(2);
        push_pass(2);
        push_pass(3);
        ready_mode    = 1;
        ddr_init_done = 1'b1;
        wait_pass(3);
        check("p3_errcnt", err_cnt, '0);
        push_pass(4);

        // One corrupted read beat, then a clean pass: the flag stays set.
        corrupt_armed = 1'b1;
        wait_pass(4);
        check("corrupt_errcnt", err_cnt, 16'd1);
        check("corrupt_errflag", err_flag_led, 1'b1);
        push_pass(5);
        ready_mode = 0;
        wait_pass(5);
        check("sticky_errcnt", err_cnt, 16'd1);
        check("sticky_errflag", err_flag_led, 1'b1);
        push_pass(6);

        // Reset in the middle of a pass.
        ready_mode    = 2;
        rst           = 1'b1;
        ddr_init_done = 1'b0;
        expq.delete();
        rdq.delete();
        step();
        step();
        check_reset_state("midrst");
        rst = 1'b0;

        // A read beat while idle is an error.
        inject_rd = 1'b1;
        step();
        step();
        check("spurious_errcnt", err_cnt, 16'd1);
        check("spurious_errflag", err_flag_led, 1'b1);

        // Fresh clean pass; with the UART built in it reports 'P'.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        ready_mode = 0;
        push_pass(0);
        push_pass(1);
        ddr_init_done = 1'b1;
        wait_pass(1);
        check("final_errcnt", err_cnt, '0);
        abort_now(1);
`ifdef TEST_DDR_UART_EN
        n = 0;
        while (rx_frames.size() == 0 && n < 400) begin
            step();
            n++;
        end
        check("uart_frame_seen", rx_frames.size() > 0, 1'b1);
        if (rx_frames.size() > 0) begin
            rx_bits = rx_frames.pop_front();
            check("uart_start", rx_bits[0], 1'b0);
            check("uart_byte", rx_bits[8:1], 8'h50);
            check("uart_stop", rx_bits[9], 1'b1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
